// File: rtl/data_mem_responder_pkg.sv
// Shared definitions for the data-memory responder: FSM state encoding and
// the width of the wait-state counter.
package data_mem_responder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_state_e;

  // Wide enough for WAIT_CYCLES up to 15.
  localparam int WAIT_CNT_W = 4;

endpackage

// File: rtl/data_mem_responder_dmem.sv
// Word-wide storage for data_mem_responder: one synchronous write port and
// one registered read port. Only the read register is reset; contents are not.
module dmem_array #(
  parameter int DEPTH_WORDS = 256,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH_WORDS];
  logic [31:0] rdata_q;
  logic [31:0] rdata_d;

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Read and write share an edge, so a simultaneous load returns the old word.
  always_comb begin
    rdata_d = rdata_q;
    if (re) rdata_d = mem[raddr];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rdata_q <= '0;
    else      rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/data_mem_responder.sv
// Wait-state data memory responder for a CPU data port (IDLE/WAIT/RESP FSM).
// Optional misalignment checking and the mem_error port: DATA_MEM_ALIGN_CHECK_EN.
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] data_addr,
  input  logic [31:0] mem_write_data,
  input  logic        mem_read,
  input  logic        mem_write,
  output logic [31:0] mem_read_data,
  output logic        mem_ready
`ifdef DATA_MEM_ALIGN_CHECK_EN
  ,
  output logic        mem_error
`endif
);

  localparam int AW = $clog2(DEPTH_WORDS);

  dmem_state_e           state_q, state_d;
  logic [WAIT_CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [AW+1:0]         addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic                  rd_q, rd_d;
  logic                  wr_q, wr_d;
  logic                  mem_ready_q, mem_ready_d;

  logic                  go_resp;
  logic [AW+1:0]         acc_addr;
  logic [31:0]           acc_wdata;
  logic                  acc_rd;
  logic                  acc_wr;
  logic                  acc_misaligned;
  logic                  array_we;
  logic                  array_re;

  logic unused_addr_bits;
  assign unused_addr_bits = ^data_addr[31:AW+2];

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rd_d       = rd_q;
    wr_d       = wr_q;
    unique case (state_q)
      IDLE: begin
        if (mem_read || mem_write) begin
          addr_d     = data_addr[AW+1:0];
          wdata_d    = mem_write_data;
          rd_d       = mem_read;
          wr_d       = mem_write;
          wait_cnt_d = WAIT_CNT_W'(WAIT_CYCLES);
          state_d    = (WAIT_CYCLES == 0) ? RESP : WAIT;
        end
      end
      WAIT: begin
        wait_cnt_d = wait_cnt_q - 1'b1;
        if (wait_cnt_q == WAIT_CNT_W'(1)) state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The access happens on the edge that enters RESP, so data is valid while
  // mem_ready is high. With zero wait states the request is still in IDLE
  // on that edge and the live inputs are used instead of the latched copy.
  assign go_resp   = (state_d == RESP);
  assign acc_addr  = (state_q == IDLE) ? data_addr[AW+1:0] : addr_q;
  assign acc_wdata = (state_q == IDLE) ? mem_write_data    : wdata_q;
  assign acc_rd    = (state_q == IDLE) ? mem_read          : rd_q;
  assign acc_wr    = (state_q == IDLE) ? mem_write         : wr_q;
  assign mem_ready_d = go_resp;

`ifdef DATA_MEM_ALIGN_CHECK_EN
  logic mem_error_q, mem_error_d;

  assign acc_misaligned = (acc_addr[1:0] != 2'b00);

  always_comb begin
    mem_error_d = mem_error_q;
    if (go_resp && acc_misaligned) mem_error_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) mem_error_q <= 1'b0;
    else      mem_error_q <= mem_error_d;
  end

  assign mem_error = mem_error_q;
`else
  assign acc_misaligned = 1'b0;
`endif

  // Store wins over a simultaneous load; the load still captures the old word.
  assign array_we = go_resp && acc_wr && !acc_misaligned;
  assign array_re = go_resp && acc_rd;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      wait_cnt_q  <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rd_q        <= 1'b0;
      wr_q        <= 1'b0;
      mem_ready_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rd_q        <= rd_d;
      wr_q        <= wr_d;
      mem_ready_q <= mem_ready_d;
    end
  end

  assign mem_ready = mem_ready_q;

  dmem_array #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .AW         (AW)
  ) u_dmem_array (
    .clk  (clk),
    .rst  (rst),
    .we   (array_we),
    .waddr(acc_addr[AW+1:2]),
    .wdata(acc_wdata),
    .re   (array_re),
    .raddr(acc_addr[AW+1:2]),
    .rdata(mem_read_data)
  );

endmodule
